// File: rtl/exc_redirect_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : exc_redirect_ctrl_pkg                                             |
// | Brief  : Shared FSM state type, exception codes and counter helper.        |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package exc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } exc_state_e;

  // Int uses the architectural cause code; ERET borrows the unused top code.
  localparam logic [4:0]  EXC_CODE_INT  = 5'h00;
  localparam logic [4:0]  EXC_CODE_ERET = 5'h1f;
  localparam logic [15:0] EXC_CNT_MAX   = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == EXC_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage : exc_redirect_ctrl_pkg
`default_nettype wire

// File: rtl/exc_redirect_ctrl_int_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : int_sync                                                          |
// | Brief  : Two-flop synchronizer for asynchronous hardware interrupt lines.  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module int_sync #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : int_sync
`default_nettype wire

// File: rtl/exc_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : exc_redirect_ctrl                                                 |
// | Brief  : M-stage exception/IRQ/ERET commit, pipeline flush and fetch       |
// |          redirect sequencer. Define INT_SYNC_EN to synchronize int_i.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module exc_redirect_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_valid_i,
  input  logic        stall_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic        eret_i,
  input  logic        irq_i,
  input  logic [5:0]  int_i,
  output logic [5:0]  int_o,
  input  logic [31:0] vec_i,
  input  logic [31:0] epc_i,
  output logic        commit_o,
  output logic [4:0]  commit_code_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        busy_o,
  output logic [15:0] exc_cnt_o
);

  import exc_redirect_ctrl_pkg::*;

  exc_state_e  r_state;
  exc_state_e  w_state_nxt;
  logic [4:0]  r_code;
  logic [31:0] r_target;
  logic        r_is_eret;
  logic [15:0] r_exc_cnt;
  logic [15:0] w_exc_cnt_nxt;
  logic        w_accept;
  logic [4:0]  w_code;
  logic [31:0] w_target;
  logic        w_is_eret;

  // Request decode, irq > exception > eret.
  always_comb begin
    w_accept  = (r_state == IDLE) && inst_valid_i && !stall_i
                && (irq_i || exc_valid_i || eret_i);
    w_code    = EXC_CODE_ERET;
    w_target  = epc_i;
    w_is_eret = 1'b1;
    if (irq_i) begin
      w_code    = EXC_CODE_INT;
      w_target  = vec_i;
      w_is_eret = 1'b0;
    end else if (exc_valid_i) begin
      w_code    = exc_code_i;
      w_target  = vec_i;
      w_is_eret = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    commit_o         = 1'b0;
    commit_code_o    = 5'd0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    busy_o           = 1'b1;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (w_accept) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        commit_o      = 1'b1;
        commit_code_o = r_code;
        flush_o       = 1'b1;
        w_state_nxt   = REDIRECT;
      end
      REDIRECT: begin
        flush_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = r_target;
        if (redirect_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        busy_o      = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_code    <= 5'd0;
      r_target  <= 32'd0;
      r_is_eret <= 1'b0;
    end else if (w_accept) begin
      r_code    <= w_code;
      r_target  <= w_target;
      r_is_eret <= w_is_eret;
    end
  end

  // Counter is rewritten every cycle so it always tracks its own held value.
  always_comb begin
    w_exc_cnt_nxt = r_exc_cnt;
    if (commit_o && !r_is_eret) begin
      w_exc_cnt_nxt = sat_inc16(r_exc_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_exc_cnt <= 16'd0;
    end else begin
      r_exc_cnt <= w_exc_cnt_nxt;
    end
  end

  assign exc_cnt_o = r_exc_cnt;

`ifdef INT_SYNC_EN
  logic [5:0] w_int_sync;

  int_sync #(
    .WIDTH (6)
  ) u_int_sync (
    .clk    (clk),
    .resetn (resetn),
    .i_d    (int_i),
    .o_q    (w_int_sync)
  );

  assign int_o = w_int_sync;
`else
  // Forced low while reset is held so every output reads 0 in reset.
  assign int_o = resetn ? int_i : 6'd0;
`endif

endmodule : exc_redirect_ctrl
`default_nettype wire

// File: tb/tb_exc_redirect_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_exc_redirect_ctrl                                              |
// | Brief  : Directed self-checking bench for exc_redirect_ctrl.               |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_exc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_valid_i;
    logic        stall_i;
    logic        exc_valid_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic        irq_i;
    logic [5:0]  int_i;
    logic [5:0]  int_o;
    logic [31:0] vec_i;
    logic [31:0] epc_i;
    logic        commit_o;
    logic [4:0]  commit_code_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic        busy_o;
    logic [15:0] exc_cnt_o;

    int tests  = 0;
    int failed = 0;
    int flush_cycles;
    int commits;

    always #5 clk = ~clk;

    exc_redirect_ctrl dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_valid_i     (inst_valid_i),
        .stall_i          (stall_i),
        .exc_valid_i      (exc_valid_i),
        .exc_code_i       (exc_code_i),
        .eret_i           (eret_i),
        .irq_i            (irq_i),
        .int_i            (int_i),
        .int_o            (int_o),
        .vec_i            (vec_i),
        .epc_i            (epc_i),
        .commit_o         (commit_o),
        .commit_code_o    (commit_code_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .redirect_ready_i (redirect_ready_i),
        .busy_o           (busy_o),
        .exc_cnt_o        (exc_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        inst_valid_i = 1'b0;
        exc_valid_i  = 1'b0;
        eret_i       = 1'b0;
        irq_i        = 1'b0;
        stall_i      = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; clear_req(); exc_code_i = 5'd0; int_i = 6'd0;
        vec_i = 32'd0; epc_i = 32'd0; redirect_ready_i = 1'b0;
        tick(); tick();
        check("rst_busy", busy_o, 1'b0);
        check("rst_commit", commit_o, 1'b0);
        check("rst_flush", flush_o, 1'b0);
        check("rst_rv", redirect_valid_o, 1'b0);
        check("rst_pc", redirect_pc_o, 32'd0);
        check("rst_cnt", exc_cnt_o, 16'd0);
        check("rst_int", int_o, 6'd0);
        resetn = 1'b1;
        tick();

        redirect_ready_i = 1'b1;
        inst_valid_i = 1'b1; exc_valid_i = 1'b1; exc_code_i = 5'h0c; vec_i = 32'hbfc00380;
        check("a_T_busy", busy_o, 1'b0);
        tick(); clear_req();
        check("a_commit", commit_o, 1'b1);
        check("a_code", commit_code_o, 5'h0c);
        check("a_flush1", flush_o, 1'b1);
        check("a_rv_low", redirect_valid_o, 1'b0);
        tick();
        check("a_rv", redirect_valid_o, 1'b1);
        check("a_pc", redirect_pc_o, 32'hbfc00380);
        check("a_commit_off", commit_o, 1'b0);
        check("a_code_zero", commit_code_o, 5'd0);
        check("a_cnt_mid", exc_cnt_o, 16'd1);
        tick();
        check("a_idle", busy_o, 1'b0);
        check("a_flush_off", flush_o, 1'b0);
        check("a_cnt", exc_cnt_o, 16'd1);

        inst_valid_i = 1'b1; irq_i = 1'b1; exc_valid_i = 1'b1; eret_i = 1'b1;
        exc_code_i = 5'h04; vec_i = 32'h80000180; epc_i = 32'h11110000;
        tick(); clear_req();
        check("b_code_int", commit_code_o, 5'h00);
        tick();
        check("b_pc_vec", redirect_pc_o, 32'h80000180);
        tick();
        check("b_cnt", exc_cnt_o, 16'd2);

        redirect_ready_i = 1'b0;
        inst_valid_i = 1'b1; eret_i = 1'b1; epc_i = 32'h80001234;
        tick(); clear_req();
        check("c_code_eret", commit_code_o, 5'h1f);
        flush_cycles = (flush_o === 1'b1) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flush_o === 1'b1) flush_cycles++;
            check("c_rv_hold", redirect_valid_o, 1'b1);
            check("c_pc_hold", redirect_pc_o, 32'h80001234);
            if (i == 4) redirect_ready_i = 1'b1;
        end
        tick();
        check("c_flush_off", flush_o, 1'b0);
        check("c_rv_off", redirect_valid_o, 1'b0);
        check("c_flush_cycles", flush_cycles, 6);
        check("c_cnt_same", exc_cnt_o, 16'd2);

        inst_valid_i = 1'b1; exc_valid_i = 1'b1; stall_i = 1'b1; exc_code_i = 5'h08;
        tick();
        check("d_stall", busy_o, 1'b0);
        stall_i = 1'b0; inst_valid_i = 1'b0;
        tick();
        check("d_invalid", busy_o, 1'b0);
        inst_valid_i = 1'b1; commits = 0;
        tick();
        check("d_busy", busy_o, 1'b1);
        if (commit_o === 1'b1) commits++;
        tick(); clear_req();
        if (commit_o === 1'b1) commits++;
        tick();
        if (commit_o === 1'b1) commits++;
        tick();
        if (commit_o === 1'b1) commits++;
        check("d_one_commit", commits, 1);
        check("d_cnt", exc_cnt_o, 16'd3);

        redirect_ready_i = 1'b0;
        inst_valid_i = 1'b1; exc_valid_i = 1'b1; exc_code_i = 5'h0a; vec_i = 32'h80000080;
        tick(); clear_req();
        tick();
        check("e_in_redirect", redirect_valid_o, 1'b1);
        resetn = 1'b0;
        tick();
        check("e_rst_busy", busy_o, 1'b0);
        check("e_rst_flush", flush_o, 1'b0);
        check("e_rst_rv", redirect_valid_o, 1'b0);
        check("e_rst_pc", redirect_pc_o, 32'd0);
        check("e_rst_commit", commit_o, 1'b0);
        check("e_rst_cnt", exc_cnt_o, 16'd0);
        resetn = 1'b1;
        commits = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (commit_o === 1'b1) commits++;
        end
        check("e_no_commit", commits, 0);
        check("e_idle", busy_o, 1'b0);

        force dut.r_exc_cnt = 16'hFFFF;
        tick();
        release dut.r_exc_cnt;
        tick();
        check("f_preload", exc_cnt_o, 16'hFFFF);
        redirect_ready_i = 1'b1;
        inst_valid_i = 1'b1; exc_valid_i = 1'b1; exc_code_i = 5'h0c;
        tick(); clear_req();
        tick(); tick();
        check("f_saturate", exc_cnt_o, 16'hFFFF);

        int_i = 6'b000001;
`ifdef INT_SYNC_EN
        check("g_sync_0", int_o, 6'd0);
        tick();
        check("g_sync_1", int_o, 6'd0);
        tick();
        check("g_sync_2", int_o, 6'b000001);
`else
        #1;
        check("g_comb", int_o, 6'b000001);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_exc_redirect_ctrl
`default_nettype wire

// File: doc/exc_redirect_ctrl.md
EXC_REDIRECT_CTRL -- requirements
Module: exc_redirect_ctrl

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock) and resetn (in, 1); reset is synchronous, active-low.
REQ-002 SHALL have inst_valid_i (in, 1): M-stage holds a non-bubble instruction.
REQ-003 SHALL have stall_i (in, 1): M stage stalled this cycle.
REQ-004 SHALL have exc_valid_i (in, 1) and exc_code_i (in, 5): synchronous exception and its code, from M.
REQ-005 SHALL have eret_i (in, 1): M-stage instruction is ERET.
REQ-006 SHALL have irq_i (in, 1): CP0 interrupt-taken condition (IE, ~EXL, IP&IM).
REQ-007 SHALL have int_i (in, 6) and int_o (out, 6): raw hardware interrupts in, interrupts forwarded to CP0 out.
REQ-008 SHALL have vec_i (in, 32) and epc_i (in, 32): CP0 handler vector and current EPC.
REQ-009 SHALL have commit_o (out, 1) and commit_code_o (out, 5): one-cycle CP0 update strobe and exception code.
REQ-010 SHALL have flush_o (out, 1): flush stages F through M.
REQ-011 SHALL have redirect_valid_o (out, 1), redirect_pc_o (out, 32) and redirect_ready_i (in, 1): fetch redirect handshake.
REQ-012 SHALL have busy_o (out, 1), high whenever state is not IDLE, and exc_cnt_o (out, 16): count of taken events.

Function
REQ-013 SHALL implement FSM states IDLE, FLUSH and REDIRECT.
REQ-014 A request SHALL be accepted in IDLE only when inst_valid_i=1, stall_i=0 and (irq_i | exc_valid_i | eret_i)=1.
REQ-015 Request priority SHALL be irq_i > exc_valid_i > eret_i; code SHALL be EXC_CODE_INT, exc_code_i, or EXC_CODE_ERET respectively.
REQ-016 On acceptance in cycle T: the code and target SHALL be latched; target = epc_i for ERET, else vec_i; next state FLUSH.
REQ-017 In FLUSH (cycle T+1): commit_o=1 for exactly this cycle, commit_code_o = latched code, flush_o=1; next state REDIRECT.
REQ-018 In REDIRECT: flush_o=1, redirect_valid_o=1, redirect_pc_o = latched target, all held stable until redirect_ready_i=1.
REQ-019 The REDIRECT state SHALL exit to IDLE in the cycle after the valid&ready handshake; flush_o and redirect_valid_o SHALL deassert there.
REQ-020 Requests arriving while not IDLE SHALL be ignored; they are not queued.
REQ-021 If redirect_ready_i=1 on entry to REDIRECT, the state SHALL last exactly one cycle, giving a minimum T-to-IDLE span of 3 cycles.
REQ-022 commit_code_o SHALL read 0 whenever commit_o=0.
REQ-023 exc_cnt_o SHALL increment on each commit_o pulse, ERET excluded, and SHALL saturate at 16'hFFFF.
REQ-024 stall_i SHALL NOT affect FLUSH or REDIRECT once a request is accepted.

Reset
REQ-025 With resetn=0 at a clock edge, state SHALL become IDLE and all outputs SHALL be 0, including int_o and exc_cnt_o.
REQ-026 Reset SHALL take effect mid-sequence, abandoning any pending redirect with no commit_o pulse emitted after it.

Configuration
REQ-027 With INT_SYNC_EN defined, int_o SHALL be int_i passed through a 2-flop synchronizer (2-cycle latency).
REQ-028 Without INT_SYNC_EN, int_o SHALL equal int_i combinationally, and the synchronizer flops SHALL not exist.

Structure
REQ-029 FSM state typedef and the EXC_CODE_INT and EXC_CODE_ERET constants SHALL live in the shared defines package.
REQ-030 The synchronizer SHALL be the sub-module int_sync (parameter WIDTH=6), instantiated only under INT_SYNC_EN.

Verification
REQ-031 exc_valid_i=1, exc_code_i=5'h0c, vec_i=32'hbfc00380 at T, ready tied 1 -> T+1 commit_o=1, code 5'h0c; T+2 redirect_pc_o=32'hbfc00380; T+3 IDLE; exc_cnt_o=1.
REQ-032 irq_i, exc_valid_i and eret_i all 1 at T -> commit_code_o=EXC_CODE_INT and redirect_pc_o=vec_i.
REQ-033 eret_i=1, epc_i=32'h80001234, ready low 4 cycles then high -> redirect_pc_o=32'h80001234 stable throughout; flush_o high for 6 cycles total; exc_cnt_o unchanged.
REQ-034 Request with stall_i=1 or inst_valid_i=0 -> no acceptance and busy_o=0; a second exc_valid_i pulse while busy_o=1 -> ignored, exactly one commit_o.
REQ-035 resetn=0 during REDIRECT -> next cycle all outputs 0 and state IDLE; exc_cnt_o preloaded to 16'hFFFF then another exception -> stays 16'hFFFF.
REQ-036 int_i=6'b000001 -> int_o follows 2 cycles later with INT_SYNC_EN, and in the same cycle without it.
